// File: rtl/fetch_pipe.sv
// fetch_pipe: fetch PC, one-cycle imem port, prefetch queue, F/D register.
// A redirect squashes the queue and the in-flight read; an empty queue bypasses.
module fetch_pipe #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] NOP      = WIDTH'(32'h00000013)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall_D,
  input  logic             flush_D,
  input  logic             redirect_E,
  input  logic [WIDTH-1:0] target_E,
  output logic [WIDTH-1:0] instr_D,
  output logic [WIDTH-1:0] PC_D,
  output logic [WIDTH-1:0] PCPlus4_D,
  output logic             valid_D
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
  } entry_t;

  logic [WIDTH-1:0] pc_F;
  logic [WIDTH-1:0] pc_inflight;
  logic             inflight;

  entry_t           q [DEPTH];
  entry_t           head;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    occ;

  logic             resp;
  logic             load;
  logic             pop_q;
  logic             bypass;
  logic             push;

  assign occ       = count + CW'(inflight);
  assign imem_req  = rst & ~redirect_E & (occ < CW'(DEPTH));
  assign imem_addr = pc_F;

  // A response only survives if execute is not redirecting this cycle.
  assign resp   = inflight & ~redirect_E;
  assign load   = ~redirect_E & ~flush_D & ~stall_D;
  assign pop_q  = load & (count != '0);
  assign bypass = load & (count == '0) & resp;
  assign push   = resp & ~bypass;
  assign head   = q[rptr];

  always_ff @(posedge clk) begin
    if (push) begin
      q[wptr] <= '{instr: imem_rdata, pc: pc_inflight};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_F        <= RESET_PC;
      pc_inflight <= '0;
      inflight    <= 1'b0;
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
    end else if (redirect_E) begin
      pc_F        <= target_E & ~WIDTH'(3);
      inflight    <= 1'b0;
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
    end else begin
      if (imem_req) begin
        pc_F        <= pc_F + WIDTH'(4);
        pc_inflight <= pc_F;
      end
      inflight <= imem_req;
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_q) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_D   <= 1'b0;
      instr_D   <= NOP;
      PC_D      <= '0;
      PCPlus4_D <= '0;
    end else begin
      priority case (1'b1)
        redirect_E, flush_D: begin
          valid_D <= 1'b0;
          instr_D <= NOP;
        end
        stall_D: begin
        end
        pop_q: begin
          valid_D   <= 1'b1;
          instr_D   <= head.instr;
          PC_D      <= head.pc;
          PCPlus4_D <= head.pc + WIDTH'(4);
        end
        bypass: begin
          valid_D   <= 1'b1;
          instr_D   <= imem_rdata;
          PC_D      <= pc_inflight;
          PCPlus4_D <= pc_inflight + WIDTH'(4);
        end
        default: begin
          valid_D <= 1'b0;
          instr_D <= NOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pipe.sv
// tb_fetch_pipe: randomized and directed checks of fetch_pipe
// against a queue-based reference model.
module tb_fetch_pipe;

  localparam int          W        = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_D;
  logic        flush_D;
  logic        redirect_E;
  logic [31:0] target_E;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] instr_D;
  logic [31:0] PC_D;
  logic [31:0] PCPlus4_D;
  logic        imem_req;
  logic        valid_D;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  bit          m_infl;
  bit          m_valid;

  fetch_pipe #(
    .WIDTH(W),
    .RESET_PC(RESET_PC),
    .DEPTH(DEPTH),
    .NOP(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .stall_D(stall_D),
    .flush_D(flush_D),
    .redirect_E(redirect_E),
    .target_E(target_E),
    .instr_D(instr_D),
    .PC_D(PC_D),
    .PCPlus4_D(PCPlus4_D),
    .valid_D(valid_D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  // Memory: data for a request appears one cycle later; junk otherwise.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom;
  end

  task automatic idle_inputs();
    stall_D    = 1'b0;
    flush_D    = 1'b0;
    redirect_E = 1'b0;
    target_E   = 32'h0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc    = RESET_PC;
    m_ipc   = 32'h0;
    m_infl  = 1'b0;
    m_valid = 1'b0;
    m_instr = NOP;
    m_pcd   = 32'h0;
  endtask

  // Compare this cycle's outputs to the model, then advance one clock.
  task automatic step();
    logic ereq;
    ent_t e;
    #1;
    ereq = rst && !redirect_E && (mq.size() + int'(m_infl) < DEPTH);
    checks++;
    if (imem_req !== ereq)
      $display("FAIL req cyc=%0d got=%b exp=%b", cyc, imem_req, ereq);
    if (imem_req !== ereq) failures++;
    if (ereq) begin
      checks++;
      if (imem_addr !== m_pc) begin
        failures++;
        $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_pc);
      end
    end
    checks++;
    if (valid_D !== m_valid) begin
      failures++;
      $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, valid_D, m_valid);
    end
    checks++;
    if (instr_D !== (m_valid ? m_instr : NOP)) begin
      failures++;
      $display("FAIL instr cyc=%0d got=%h exp=%h", cyc, instr_D,
               m_valid ? m_instr : NOP);
    end
    if (m_valid) begin
      checks++;
      if (PC_D !== m_pcd || PCPlus4_D !== m_pcd + 32'd4) begin
        failures++;
        $display("FAIL pc cyc=%0d got=%h/%h exp=%h/%h", cyc, PC_D,
                 PCPlus4_D, m_pcd, m_pcd + 32'd4);
      end
    end
    if (redirect_E) begin
      mq.delete();
      m_infl  = 1'b0;
      m_pc    = target_E & ~32'd3;
      m_valid = 1'b0;
      m_instr = NOP;
    end else begin
      if (m_infl) mq.push_back('{instr: mem_word(m_ipc), pc: m_ipc});
      checks++;
      if (mq.size() > DEPTH) begin
        failures++;
        $display("FAIL occupancy cyc=%0d got=%0d exp<=%0d", cyc,
                 mq.size(), DEPTH);
      end
      if (flush_D) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end else if (!stall_D) begin
        if (mq.size() > 0) begin
          e       = mq.pop_front();
          m_valid = 1'b1;
          m_instr = e.instr;
          m_pcd   = e.pc;
        end else begin
          m_valid = 1'b0;
          m_instr = NOP;
        end
      end
      if (ereq) begin
        m_ipc  = m_pc;
        m_pc   = m_pc + 32'd4;
        m_infl = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  // Asserts reset immediately, checks async clear, releases on a negedge.
  task automatic apply_reset();
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (valid_D !== 1'b0 || instr_D !== NOP || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_ctl got=%b/%h/%b exp=0/%h/0", valid_D, instr_D,
               imem_req, NOP);
    end
    checks++;
    if (PC_D !== 32'h0 || PCPlus4_D !== 32'h0) begin
      failures++;
      $display("FAIL rst_pc got=%h/%h exp=0/0", PC_D, PCPlus4_D);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL cyc0_req got=%b/%h exp=1/%h", imem_req, imem_addr,
               RESET_PC);
    end
    step();
    #1;
    checks++;
    if (valid_D !== 1'b0) begin
      failures++;
      $display("FAIL cyc1_valid got=%b exp=0", valid_D);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (valid_D !== 1'b1 || PC_D !== RESET_PC + 32'(4 * i) ||
          PCPlus4_D !== RESET_PC + 32'(4 * i + 4)) begin
        failures++;
        $display("FAIL stream i=%0d got=%b/%h/%h exp=1/%h", i, valid_D,
                 PC_D, PCPlus4_D, RESET_PC + 32'(4 * i));
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    #1;
    held    = PC_D;
    stall_D = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i > 0) begin
        checks++;
        if (PC_D !== held || valid_D !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold i=%0d got=%h exp=%h", i, PC_D, held);
        end
      end
      if (i >= 3) begin
        checks++;
        if (imem_req !== 1'b0) begin
          failures++;
          $display("FAIL stall_gate i=%0d got=%b exp=0", i, imem_req);
        end
      end
      step();
    end
    stall_D = 1'b0;
    for (int j = 0; j < 6; j++) begin
      #1;
      checks++;
      if (PC_D !== held + 32'(4 * j) || valid_D !== 1'b1) begin
        failures++;
        $display("FAIL stall_resume j=%0d got=%h exp=%h", j, PC_D,
                 held + 32'(4 * j));
      end
      if (j < 2) begin
        checks++;
        if (imem_req !== (j == 1)) begin
          failures++;
          $display("FAIL req_resume j=%0d got=%b exp=%b", j, imem_req,
                   j == 1);
        end
      end
      step();
    end
  endtask

  task automatic test_redirect();
    stall_D = 1'b1;
    repeat (2) step();
    redirect_E = 1'b1;
    target_E   = 32'h00000103;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL redir_noreq got=%b exp=0", imem_req);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || valid_D !== 1'b0) begin
      failures++;
      $display("FAIL redir_n1 got=%b/%h/%b exp=1/00000100/0", imem_req,
               imem_addr, valid_D);
    end
    step();
    #1;
    checks++;
    if (valid_D !== 1'b0) begin
      failures++;
      $display("FAIL redir_n2 got=%b exp=0", valid_D);
    end
    step();
    #1;
    checks++;
    if (valid_D !== 1'b1 || PC_D !== 32'h100 ||
        instr_D !== mem_word(32'h100)) begin
      failures++;
      $display("FAIL redir_n3 got=%b/%h/%h exp=1/00000100/%h", valid_D,
               PC_D, instr_D, mem_word(32'h100));
    end
    repeat (3) step();
  endtask

  task automatic test_flush();
    logic [31:0] held;
    #1;
    held    = PC_D;
    stall_D = 1'b1;
    repeat (3) step();
    flush_D = 1'b1;
    step();
    idle_inputs();
    #1;
    checks++;
    if (valid_D !== 1'b0 || instr_D !== NOP) begin
      failures++;
      $display("FAIL flush_bubble got=%b/%h exp=0/%h", valid_D, instr_D, NOP);
    end
    step();
    #1;
    checks++;
    if (valid_D !== 1'b1 || PC_D !== held + 32'd4) begin
      failures++;
      $display("FAIL flush_head got=%b/%h exp=1/%h", valid_D, PC_D,
               held + 32'd4);
    end
    repeat (3) step();
  endtask

  task automatic test_wrap();
    bit seen;
    seen       = 1'b0;
    redirect_E = 1'b1;
    target_E   = 32'hFFFFFFF4;
    step();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hFFFFFFF4 + 32'(4 * k)) begin
        failures++;
        $display("FAIL wrap_addr k=%0d got=%b/%h exp=1/%h", k, imem_req,
                 imem_addr, 32'hFFFFFFF4 + 32'(4 * k));
      end
      step();
    end
    for (int k = 0; k < 8; k++) begin
      #1;
      if (valid_D === 1'b1 && PC_D === 32'hFFFFFFFC) begin
        seen = 1'b1;
        checks++;
        if (PCPlus4_D !== 32'h0) begin
          failures++;
          $display("FAIL wrap_plus4 got=%h exp=00000000", PCPlus4_D);
        end
      end
      step();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wrap_seen got=0 exp=1");
    end
  endtask

  task automatic test_reset_mid();
    bit reached;
    reached = 1'b0;
    stall_D = 1'b1;
    for (int i = 0; i < 10 && !reached; i++) begin
      step();
      reached = (mq.size() == 3) && m_infl;
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL mid_setup got=%0d exp=3", mq.size());
    end
    apply_reset();
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL mid_restart got=%b/%h exp=1/%h", imem_req, imem_addr,
               RESET_PC);
    end
    repeat (2) step();
    #1;
    checks++;
    if (valid_D !== 1'b1 || PC_D !== RESET_PC) begin
      failures++;
      $display("FAIL mid_first got=%b/%h exp=1/%h", valid_D, PC_D, RESET_PC);
    end
    repeat (4) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall_D    = ($urandom_range(0, 99) < 30);
      flush_D    = ($urandom_range(0, 99) < 5);
      redirect_E = ($urandom_range(0, 99) < 5);
      target_E   = $urandom;
      step();
    end
    idle_inputs();
    repeat (8) step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_stall();
    test_redirect();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
